fetch_unit: RTL and testbench

Instruction-fetch front end feeding the decode/register-read stage of the 5-stage core. It replaces the core's direct combinational instruction-memory read.
- Generates sequential fetch addresses.
- Issues requests to a variable-latency instruction memory over a req/gnt + rvalid handshake.
- Buffers returned instructions with their PCs in a small prefetch queue.
- Presents them to decode with a valid/ready handshake.
- Branch/jump redirects from execute flush the queue and discard in-flight responses.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 65 ++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the prefetch queue entry type
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSN = 32'h00000013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h00000000;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ins;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count
module fetch_fifo #(
   parameter int W = 64,
   parameter int D = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [W-1:0]         din,
   input  logic                 pop,
   input  logic                 flush,
   output logic [W-1:0]         dout,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(D+1)-1:0] count
);
   localparam int AW = D > 1 ? $clog2(D) : 1;
   localparam int CW = $clog2(D + 1);
   logic [W-1:0] mem [D];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_pop;
   // explicit wrap so non-power-of-two depths work
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (32'(p) == D - 1) ? '0 : p + AW'(1);
   endfunction
   assign empty = count == '0;
   assign full = 32'(count) == D;
   assign do_pop = pop && !empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         if (do_pop) rd_ptr <= inc(rd_ptr);
         count <= count + CW'(push) - CW'(do_pop);
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with credit-limited imem requests,
// prefetch queue, and redirect flush that drops in-flight responses
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int DEPTH = 4,
   parameter int MAX_OUT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_ins
);
   localparam int QCW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   fetch_entry_t head;
   logic [XLEN-1:0] fetch_pc, tag_pc;
   logic [QCW-1:0] q_count;
   logic [OW-1:0] outstanding, outstanding_nxt, drop;
   logic q_full, q_empty, tag_full, tag_empty, grant, push, pop;
   // queue slots plus in-flight requests never exceed DEPTH, so a push always fits
   assign imem_req = rst_n && !redirect && 32'(q_count) + 32'(outstanding) < DEPTH
                     && 32'(outstanding) < MAX_OUT;
   assign imem_addr = fetch_pc;
   assign grant = imem_req && imem_gnt;
   assign push = imem_rvalid && drop == '0 && !redirect;
   assign pop = out_valid && out_ready;
   assign outstanding_nxt = outstanding + OW'(grant) - OW'(imem_rvalid);
   assign out_valid = !q_empty;
   assign out_pc = out_valid ? head.pc : '0;
   assign out_ins = out_valid ? head.ins : NOP_INSN;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         drop <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
         drop <= outstanding_nxt;
      end else begin
         if (grant) fetch_pc <= fetch_pc + XLEN'(4);
         if (imem_rvalid && drop != '0) drop <= drop - OW'(1);
      end
   fetch_fifo #(.W($bits(fetch_entry_t)), .D(DEPTH)) u_queue (
      .clk(clk), .rst_n(rst_n), .push(push), .din({tag_pc, imem_rdata}), .pop(pop),
      .flush(redirect), .dout(head), .full(q_full), .empty(q_empty), .count(q_count)
   );
   // tags are never flushed: dropped responses still retire their own tag
   fetch_fifo #(.W(XLEN), .D(MAX_OUT)) u_tags (
      .clk(clk), .rst_n(rst_n), .push(grant), .din(fetch_pc), .pop(imem_rvalid),
      .flush(1'b0), .dout(tag_pc), .full(tag_full), .empty(tag_empty), .count(outstanding)
   );
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> (!q_full || pop));
   a_tag_room: assert property (@(posedge clk) disable iff (!rst_n) grant |-> !tag_full);
   a_tag_avail: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> !tag_empty);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus checked every cycle against a queue-level fetch model
module tb_fetch_unit;
   logic clk = 0, rst_n = 0, redirect = 0, imem_gnt = 0, imem_rvalid = 0, out_ready = 0;
   logic [31:0] redirect_pc = 0, imem_rdata = 0;
   logic imem_req, out_valid;
   logic [31:0] imem_addr, out_pc, out_ins;
   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins)
   );
   always #5 clk = ~clk;
   int total = 0, bad = 0;
   logic [31:0] mq_pc[$], mq_ins[$], pend_addr[$], seen[$], granted[$];
   int pend_due[$];
   logic [31:0] m_pc, victim;
   int m_out, m_drop, cyc, lat;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   task automatic clear_log();
      seen.delete();
      granted.delete();
   endtask
   task automatic step(input logic rd, input logic [31:0] rpc, input logic g, input logic rdy);
      logic rv, exp_req, exp_valid, grant, pop;
      logic [31:0] rv_addr;
      @(negedge clk);
      rv = pend_addr.size() > 0 && pend_due[0] <= cyc;
      rv_addr = rv ? pend_addr[0] : 32'h0;
      redirect = rd;
      redirect_pc = rpc;
      imem_gnt = g;
      out_ready = rdy;
      imem_rvalid = rv;
      imem_rdata = rv ? rv_addr ^ 32'hA5A5A5A5 : 32'hDEADBEEF;
      #1;
      exp_valid = mq_pc.size() > 0;
      exp_req = !rd && mq_pc.size() + m_out < 4 && m_out < 2;
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_pc", out_pc, exp_valid ? mq_pc[0] : 32'h0);
      check("out_ins", out_ins, exp_valid ? mq_ins[0] : 32'h13);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      grant = exp_req && g;
      pop = exp_valid && rdy;
      if (rv) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (grant) begin
         pend_addr.push_back(m_pc);
         pend_due.push_back(cyc + lat);
         granted.push_back(m_pc);
      end
      m_out += int'(grant) - int'(rv);
      if (rd) begin
         mq_pc.delete();
         mq_ins.delete();
         m_drop = m_out;
         m_pc = rpc & ~32'h3;
      end else begin
         if (pop) begin
            seen.push_back(mq_pc[0]);
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
         end
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
               mq_pc.push_back(rv_addr);
               mq_ins.push_back(rv_addr ^ 32'hA5A5A5A5);
            end
         end
         if (grant) m_pc += 4;
      end
      cyc++;
   endtask
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ins", out_ins, 32'h00000013);
      check("rst_pc", out_pc, 32'h0);
      redirect = 0;
      imem_gnt = 0;
      imem_rvalid = 0;
      out_ready = 0;
      mq_pc.delete();
      mq_ins.delete();
      pend_addr.delete();
      pend_due.delete();
      clear_log();
      m_pc = 0;
      m_out = 0;
      m_drop = 0;
      cyc = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int found;
      lat = 1;
      do_reset();
      for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
      check("first_addr", granted[0], 32'h0);
      check("stream_count", 32'(seen.size()), 32'd10);
      for (int i = 0; i < 10; i++) check("stream_pc", seen[i], 32'(4 * i));
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
      check("bp_grants", 32'(granted.size()), 32'd4);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
      check("bp_pc0", seen[0], 32'h0);
      check("bp_pc1", seen[1], 32'h4);
      check("bp_pc2", seen[2], 32'h8);
      check("bp_pc3", seen[3], 32'hC);
      check("bp_pc4", seen[4], 32'h10);
      do_reset();
      lat = 3;
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      check("redir_outstanding", 32'(m_out), 32'd2);
      step(1, 32'h00000103, 1, 1);
      clear_log();
      for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
      check("redir_addr", granted[0], 32'h100);
      check("redir_pc", seen[0], 32'h100);
      do_reset();
      lat = 1;
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
      victim = pend_addr[0];
      check("victim_addr", victim, 32'h10);
      step(1, 32'h00000200, 1, 1);
      clear_log();
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
      check("coinc_pc", seen[0], 32'h200);
      found = 0;
      foreach (seen[i]) if (seen[i] == victim) found = 1;
      check("victim_absent", 32'(found), 32'h0);
      lat = 3;
      step(1, 32'h00000300, 1, 1);
      step(1, 32'h00000402, 1, 1);
      clear_log();
      for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
      check("b2b_addr", granted[0], 32'h400);
      check("b2b_pc", seen[0], 32'h400);
      lat = 2;
      for (int i = 0; i < 30; i++) step(0, 0, logic'(i % 3 != 0), logic'(i % 4 != 1));
      lat = 1;
      step(1, 32'hFFFFFFF8, 1, 1);
      clear_log();
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
      check("wrap_pc0", seen[0], 32'hFFFFFFF8);
      check("wrap_pc1", seen[1], 32'hFFFFFFFC);
      check("wrap_pc2", seen[2], 32'h00000000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
